uart_rx_io: RTL and testbench

// - UART receiver that deserializes the external rx line into T-bit bytes and writes each

---
 rtl/uart_rx_io_pkg.sv | 15 +
 rtl/uart_rx_io_if.sv | 28 ++
 rtl/uart_rx_io_sync2.sv | 20 ++
 rtl/uart_rx_io.sv | 114 +++++++++++
 tb/tb_uart_rx_io.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_io_pkg.sv
// Shared UART definitions: receiver state encodings and default bit timing.
// Imported by the receiver, the I/O bank and the TX block.
package uart_rx_io_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

endpackage

// File: rtl/uart_rx_io_if.sv
// Write port from the UART receiver to the I/O register bank.
// master: data_IO_in, habilitar, entradaDeco, frame_err, busy out.
interface uart_rx_io_if #(
  parameter int T = 8,
  parameter int N = 5
);
  logic [T-1:0] data_IO_in;
  logic         habilitar;
  logic [N-1:0] entradaDeco;
  logic         frame_err;
  logic         busy;

  modport master (
    output data_IO_in,
    output habilitar,
    output entradaDeco,
    output frame_err,
    output busy
  );

  modport slave (
    input data_IO_in,
    input habilitar,
    input entradaDeco,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_io_sync2.sv
// Two-flop synchronizer for the asynchronous rx line; resets to idle (1).
// Ports: clk, rst (sync, active high), d (async in), q (synced out).
module uart_rx_io_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx_io.sv
// UART receiver writing each good byte into I/O register RX_SEL.
// Ports: clk, rst (sync, active high), rx (async serial), bus (master).
module uart_rx_io
  import uart_rx_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int T            = 8,
  parameter int N            = 5,
  parameter int RX_SEL       = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  uart_rx_io_if.master bus
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(T + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  state_t        state;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bitc;
  logic [T-1:0]  shreg;

  uart_rx_io_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bitc            <= '0;
      shreg           <= '0;
      bus.data_IO_in  <= '0;
      bus.habilitar   <= 1'b0;
      bus.entradaDeco <= '0;
      bus.frame_err   <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      // write and error strobes are single-cycle
      bus.habilitar   <= 1'b0;
      bus.entradaDeco <= '0;
      bus.frame_err   <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state    <= S_START;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= S_DATA;
              bitc  <= '0;
            end else begin
              state    <= S_IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[T-1:1]};
            if (bitc == BW'(T - 1)) begin
              state <= S_STOP;
            end else begin
              bitc <= bitc + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt      <= '0;
            bus.busy <= 1'b0;
            if (rx_s) begin
              state           <= S_IDLE;
              bus.habilitar   <= 1'b1;
              bus.entradaDeco <= N'(RX_SEL);
              bus.data_IO_in  <= shreg;
            end else begin
              state         <= S_BRK;
              bus.frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_BRK: begin
          // a line held low must go high before a new start
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_io.sv
// Directed self-checking bench for uart_rx_io.
// CLKS_PER_BIT=16, T=8, N=5, RX_SEL=1.
module tb_uart_rx_io;
  localparam int CPB = 16;
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  int hab_cnt  = 0;
  int fe_cnt   = 0;
  int both_cnt = 0;
  int hab_cyc[$];
  logic [7:0] hab_dat[$];
  logic [4:0] hab_sel[$];
  int fall_cyc;

  uart_rx_io_if #(.T(8), .N(5)) bus ();

  uart_rx_io #(
    .CLKS_PER_BIT (CPB),
    .T            (8),
    .N            (5),
    .RX_SEL       (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.habilitar === 1'b1) begin
      hab_cnt++;
      hab_cyc.push_back(cyc);
      hab_dat.push_back(bus.data_IO_in);
      hab_sel.push_back(bus.entradaDeco);
    end
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.habilitar === 1'b1 && bus.frame_err === 1'b1) both_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    fall_cyc = cyc;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  task automatic chk_frame(input string nm, input int h0,
                           input logic [7:0] exp);
    int d;
    vecs++;
    if (hab_cnt - h0 !== 1) begin
      errs++;
      $display("FAIL %s pulses: got %0d want 1", nm, hab_cnt - h0);
    end else begin
      vecs++;
      if (hab_dat[$] !== exp) begin
        errs++;
        $display("FAIL %s data: got %h want %h", nm, hab_dat[$], exp);
      end
      vecs++;
      if (hab_sel[$] !== 5'd1) begin
        errs++;
        $display("FAIL %s sel: got %0d want 1", nm, hab_sel[$]);
      end
      d = hab_cyc[$] - fall_cyc;
      vecs++;
      if (d < LAT - 1 || d > LAT + 1) begin
        errs++;
        $display("FAIL %s latency: got %0d want %0d+/-1", nm, d, LAT);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    idle(3);
    vecs++;
    if (bus.data_IO_in !== 8'h00) begin
      errs++;
      $display("FAIL reset data: got %h want 00", bus.data_IO_in);
    end
    vecs++;
    if (bus.habilitar !== 1'b0 || bus.frame_err !== 1'b0) begin
      errs++;
      $display("FAIL reset strobes: got %b%b want 00",
               bus.habilitar, bus.frame_err);
    end
    vecs++;
    if (bus.entradaDeco !== 5'd0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset sel/busy: got %0d/%b want 0/0",
               bus.entradaDeco, bus.busy);
    end
    rst = 1'b0;
    idle(4);
  endtask

  task automatic test_frame_a5();
    int h0 = hab_cnt;
    int f0 = fe_cnt;
    send_frame(8'hA5, 1'b1);
    idle(8);
    chk_frame("a5", h0, 8'hA5);
    vecs++;
    if (fe_cnt !== f0) begin
      errs++;
      $display("FAIL a5 frame_err: got %0d want 0", fe_cnt - f0);
    end
    vecs++;
    if (bus.data_IO_in !== 8'hA5) begin
      errs++;
      $display("FAIL a5 hold: got %h want a5", bus.data_IO_in);
    end
  endtask

  task automatic test_glitch();
    int h0 = hab_cnt;
    int n  = 0;
    bit seen = 0;
    @(negedge clk);
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    while (n < 12 && !(seen && bus.busy === 1'b0)) begin
      if (bus.busy === 1'b1) seen = 1;
      @(negedge clk);
      n++;
    end
    vecs++;
    if (!seen || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL glitch busy: seen=%0d busy=%b want seen=1 busy=0",
               seen, bus.busy);
    end
    idle(CPB * 12);
    vecs++;
    if (hab_cnt !== h0) begin
      errs++;
      $display("FAIL glitch write: got %0d want 0", hab_cnt - h0);
    end
  endtask

  task automatic test_frame_err();
    int h0 = hab_cnt;
    int f0 = fe_cnt;
    int bz = 0;
    send_frame(8'h3C, 1'b0);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bz++;
    end
    vecs++;
    if (fe_cnt - f0 !== 1) begin
      errs++;
      $display("FAIL ferr pulses: got %0d want 1", fe_cnt - f0);
    end
    vecs++;
    if (hab_cnt !== h0) begin
      errs++;
      $display("FAIL ferr write: got %0d want 0", hab_cnt - h0);
    end
    vecs++;
    if (bz !== 0) begin
      errs++;
      $display("FAIL ferr break busy: got %0d want 0", bz);
    end
    rx = 1'b1;
    idle(20);
    h0 = hab_cnt;
    send_frame(8'h55, 1'b1);
    idle(8);
    chk_frame("55", h0, 8'h55);
  endtask

  task automatic test_back_to_back();
    int h0 = hab_cnt;
    int d;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(8);
    vecs++;
    if (hab_cnt - h0 !== 2) begin
      errs++;
      $display("FAIL b2b pulses: got %0d want 2", hab_cnt - h0);
    end else begin
      vecs++;
      if (hab_dat[$-1] !== 8'h00 || hab_dat[$] !== 8'hFF) begin
        errs++;
        $display("FAIL b2b data: got %h,%h want 00,ff",
                 hab_dat[$-1], hab_dat[$]);
      end
      d = hab_cyc[$] - hab_cyc[$-1];
      vecs++;
      if (d < 159 || d > 161) begin
        errs++;
        $display("FAIL b2b spacing: got %0d want 160+/-1", d);
      end
    end
  endtask

  task automatic test_reset_mid();
    int h0 = hab_cnt;
    logic [7:0] b = 8'h81;
    @(negedge clk);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(CPB);
    end
    vecs++;
    if (bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL mid busy: got %b want 1", bus.busy);
    end
    rst = 1'b1;
    rx  = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(CPB * 8);
    vecs++;
    if (hab_cnt !== h0 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL mid abort: writes=%0d busy=%b want 0/0",
               hab_cnt - h0, bus.busy);
    end
    h0 = hab_cnt;
    send_frame(8'h42, 1'b1);
    idle(8);
    chk_frame("42", h0, 8'h42);
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    vecs++;
    if (both_cnt !== 0) begin
      errs++;
      $display("FAIL overlap: got %0d want 0", both_cnt);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
